// File: rtl/mem_stage_if.sv
// Data-memory request/stall/done bus between the memory stage (master) and the data memory (slave).
`timescale 1ns/1ps
interface mem_stage_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_rd;
    logic              mem_wr;
    logic              mem_stall;
    logic              mem_done;
    logic [DATA_W-1:0] mem_data_out;

    // Handshake: a request (mem_rd/mem_wr) is accepted in a cycle where mem_stall=0;
    // mem_done=1 (same cycle for a hit, later for a miss) ends the access with read data valid.
    modport master (
        output mem_addr, mem_data_in, mem_rd, mem_wr,
        input  mem_stall, mem_done, mem_data_out
    );
    modport slave (
        input  mem_addr, mem_data_in, mem_rd, mem_wr,
        output mem_stall, mem_done, mem_data_out
    );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM register, one-at-a-time load/store sequencer against a
// stalling data memory, and the MEM/WB register feeding writeback.
`timescale 1ns/1ps
module mem_stage #(
    parameter int DATA_W  = 16,
    parameter int REG_W   = 3,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic [DATA_W-1:0] ex_wr_data,
    input  logic              ex_mem_rd,
    input  logic              ex_mem_wr,
    input  logic              ex_reg_wr,
    input  logic [REG_W-1:0]  ex_wr_reg,
    input  logic              ex_halt,
    output logic              ex_stall,
    mem_stage_if.master       mbus,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_reg_wr,
    output logic [REG_W-1:0]  wb_wr_reg,
    output logic              wb_halt,
    output logic              err,
    output logic [1:0]        state_dbg
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_alu_out_q, m_alu_out_d;
    logic [DATA_W-1:0] m_wr_data_q, m_wr_data_d;
    logic              m_mem_rd_q, m_mem_rd_d;
    logic              m_mem_wr_q, m_mem_wr_d;
    logic              m_reg_wr_q, m_reg_wr_d;
    logic [REG_W-1:0]  m_wr_reg_q, m_wr_reg_d;
    logic              m_halt_q, m_halt_d;

    logic              wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              wb_reg_wr_q, wb_reg_wr_d;
    logic [REG_W-1:0]  wb_wr_reg_q, wb_wr_reg_d;
    logic              wb_halt_q, wb_halt_d;

    logic is_store, is_load, m_mem, in_idle, in_issue, in_wait, complete;

    // A valid op with both rd and wr set is handled as a store.
    assign is_store = m_valid_q & m_mem_wr_q;
    assign is_load  = m_valid_q & m_mem_rd_q & ~m_mem_wr_q;
    assign m_mem    = is_store | is_load;
    assign in_idle  = (state_q == S_IDLE);
    assign in_issue = (state_q == S_ISSUE);
    assign in_wait  = (state_q == S_WAIT);
    assign complete = (in_issue & ~mbus.mem_stall & mbus.mem_done) | (in_wait & mbus.mem_done);
    assign ex_stall = m_mem & ~complete;

    assign mbus.mem_addr    = m_valid_q ? m_alu_out_q : '0;
    assign mbus.mem_data_in = m_valid_q ? m_wr_data_q : '0;
    assign mbus.mem_rd      = in_issue & is_load;
    assign mbus.mem_wr      = in_issue & is_store;

    assign wb_valid  = wb_valid_q;
    assign wb_data   = wb_data_q;
    assign wb_reg_wr = wb_valid_q & wb_reg_wr_q;
    assign wb_wr_reg = wb_wr_reg_q;
    assign wb_halt   = wb_valid_q & wb_halt_q;
    assign err       = err_q;
    assign state_dbg = state_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        m_valid_d   = m_valid_q;
        m_alu_out_d = m_alu_out_q;
        m_wr_data_d = m_wr_data_q;
        m_mem_rd_d  = m_mem_rd_q;
        m_mem_wr_d  = m_mem_wr_q;
        m_reg_wr_d  = m_reg_wr_q;
        m_wr_reg_d  = m_wr_reg_q;
        m_halt_d    = m_halt_q;
        if (!ex_stall) begin
            m_valid_d   = ex_valid;
            m_alu_out_d = ex_alu_out;
            m_wr_data_d = ex_wr_data;
            m_mem_rd_d  = ex_mem_rd;
            m_mem_wr_d  = ex_mem_wr;
            m_reg_wr_d  = ex_reg_wr;
            m_wr_reg_d  = ex_wr_reg;
            m_halt_d    = ex_halt;
            state_d     = (ex_valid & (ex_mem_rd | ex_mem_wr)) ? S_ISSUE : S_IDLE;
            cnt_d       = '0;
        end else if (in_issue & ~mbus.mem_stall & ~mbus.mem_done) begin
            state_d = S_WAIT;
            cnt_d   = '0;
        end else if (in_wait & ~mbus.mem_done & (cnt_q != CNT_W'(TIMEOUT))) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Timeout fires on the cycle the counter steps onto TIMEOUT; waiting continues.
        err_d = err_q
              | (m_valid_q & m_mem_rd_q & m_mem_wr_q)
              | (mbus.mem_done & (in_idle | (in_issue & mbus.mem_stall)))
              | (in_wait & ~mbus.mem_done & (cnt_q == CNT_W'(TIMEOUT - 1)));

        wb_valid_d  = (m_valid_q & ~m_mem) | complete;
        wb_data_d   = wb_data_q;
        wb_reg_wr_d = wb_reg_wr_q;
        wb_wr_reg_d = wb_wr_reg_q;
        wb_halt_d   = wb_halt_q;
        if (wb_valid_d) begin
            wb_data_d   = is_load ? mbus.mem_data_out : m_alu_out_q;
            wb_reg_wr_d = m_reg_wr_q & ~is_store;
            wb_wr_reg_d = m_wr_reg_q;
            wb_halt_d   = m_halt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            m_valid_q   <= 1'b0;
            m_alu_out_q <= '0;
            m_wr_data_q <= '0;
            m_mem_rd_q  <= 1'b0;
            m_mem_wr_q  <= 1'b0;
            m_reg_wr_q  <= 1'b0;
            m_wr_reg_q  <= '0;
            m_halt_q    <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_reg_wr_q <= 1'b0;
            wb_wr_reg_q <= '0;
            wb_halt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            m_valid_q   <= m_valid_d;
            m_alu_out_q <= m_alu_out_d;
            m_wr_data_q <= m_wr_data_d;
            m_mem_rd_q  <= m_mem_rd_d;
            m_mem_wr_q  <= m_mem_wr_d;
            m_reg_wr_q  <= m_reg_wr_d;
            m_wr_reg_q  <= m_wr_reg_d;
            m_halt_q    <= m_halt_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_reg_wr_q <= wb_reg_wr_d;
            wb_wr_reg_q <= wb_wr_reg_d;
            wb_halt_q   <= wb_halt_d;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU op, load hit, stalled load miss with a
// back-to-back ALU op, store, timeout, and reset in the middle of a wait.
`timescale 1ns/1ps
module tb_mem_stage;
    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [15:0] ex_alu_out;
    logic [15:0] ex_wr_data;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic        ex_reg_wr;
    logic [2:0]  ex_wr_reg;
    logic        ex_halt;
    logic        ex_stall;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic        wb_reg_wr;
    logic [2:0]  wb_wr_reg;
    logic        wb_halt;
    logic        err;
    logic [1:0]  state_dbg;

    int errors = 0;
    int checks = 0;

    mem_stage_if #(.DATA_W(16)) mif ();

    mem_stage #(.DATA_W(16), .REG_W(3), .TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_alu_out (ex_alu_out),
        .ex_wr_data (ex_wr_data),
        .ex_mem_rd  (ex_mem_rd),
        .ex_mem_wr  (ex_mem_wr),
        .ex_reg_wr  (ex_reg_wr),
        .ex_wr_reg  (ex_wr_reg),
        .ex_halt    (ex_halt),
        .ex_stall   (ex_stall),
        .mbus       (mif.master),
        .wb_valid   (wb_valid),
        .wb_data    (wb_data),
        .wb_reg_wr  (wb_reg_wr),
        .wb_wr_reg  (wb_wr_reg),
        .wb_halt    (wb_halt),
        .err        (err),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_ex(input logic v, input logic [15:0] alu, input logic [15:0] wd,
                            input logic rd, input logic wr, input logic rw, input logic [2:0] rg);
        ex_valid   = v;
        ex_alu_out = alu;
        ex_wr_data = wd;
        ex_mem_rd  = rd;
        ex_mem_wr  = wr;
        ex_reg_wr  = rw;
        ex_wr_reg  = rg;
    endtask

    initial begin
        rst_n = 1'b0;
        ex_halt = 1'b0;
        drive_ex(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0);
        mif.mem_stall    = 1'b0;
        mif.mem_done     = 1'b0;
        mif.mem_data_out = 16'h0;
        #1;
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_mem_rd", {31'd0, mif.mem_rd}, 32'd0);
        chk("rst_ex_stall", {31'd0, ex_stall}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ALU op
        drive_ex(1'b1, 16'h1234, 16'h0, 1'b0, 1'b0, 1'b1, 3'd5);
        tick();
        drive_ex(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0);
        #1;
        chk("alu_ex_stall", {31'd0, ex_stall}, 32'd0);
        chk("alu_mem_rd", {31'd0, mif.mem_rd}, 32'd0);
        chk("alu_wb_early", {31'd0, wb_valid}, 32'd0);
        tick();
        chk("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("alu_wb_data", {16'd0, wb_data}, 32'h1234);
        chk("alu_wb_wr_reg", {29'd0, wb_wr_reg}, 32'd5);
        chk("alu_wb_reg_wr", {31'd0, wb_reg_wr}, 32'd1);
        tick();
        chk("alu_wb_one_cycle", {31'd0, wb_valid}, 32'd0);

        // Load hit
        drive_ex(1'b1, 16'h0040, 16'h0, 1'b1, 1'b0, 1'b1, 3'd2);
        tick();
        drive_ex(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0);
        mif.mem_done = 1'b1;
        mif.mem_data_out = 16'hBEEF;
        #1;
        chk("hit_mem_rd", {31'd0, mif.mem_rd}, 32'd1);
        chk("hit_mem_addr", {16'd0, mif.mem_addr}, 32'h0040);
        chk("hit_ex_stall", {31'd0, ex_stall}, 32'd0);
        tick();
        mif.mem_done = 1'b0;
        mif.mem_data_out = 16'h0;
        #1;
        chk("hit_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("hit_wb_data", {16'd0, wb_data}, 32'hBEEF);
        chk("hit_mem_rd_off", {31'd0, mif.mem_rd}, 32'd0);
        tick();

        // Load miss with stalls, followed by back-to-back ALU op
        drive_ex(1'b1, 16'h0080, 16'h0, 1'b1, 1'b0, 1'b1, 3'd3);
        tick();
        drive_ex(1'b1, 16'h0007, 16'h0, 1'b0, 1'b0, 1'b1, 3'd4);
        mif.mem_stall = 1'b1;
        #1;
        chk("miss_rd_c1", {31'd0, mif.mem_rd}, 32'd1);
        chk("miss_stall_c1", {31'd0, ex_stall}, 32'd1);
        tick();
        chk("miss_rd_c2", {31'd0, mif.mem_rd}, 32'd1);
        chk("miss_stall_c2", {31'd0, ex_stall}, 32'd1);
        tick();
        mif.mem_stall = 1'b0;
        #1;
        chk("miss_rd_c3", {31'd0, mif.mem_rd}, 32'd1);
        chk("miss_stall_c3", {31'd0, ex_stall}, 32'd1);
        tick();
        chk("miss_rd_w1", {31'd0, mif.mem_rd}, 32'd0);
        chk("miss_stall_w1", {31'd0, ex_stall}, 32'd1);
        chk("miss_state_w1", {30'd0, state_dbg}, 32'd2);
        tick();
        chk("miss_stall_w2", {31'd0, ex_stall}, 32'd1);
        chk("miss_wb_w2", {31'd0, wb_valid}, 32'd0);
        tick();
        mif.mem_done = 1'b1;
        mif.mem_data_out = 16'h5A5A;
        #1;
        chk("miss_stall_done", {31'd0, ex_stall}, 32'd0);
        tick();
        drive_ex(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0);
        mif.mem_done = 1'b0;
        mif.mem_data_out = 16'h0;
        chk("miss_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("miss_wb_data", {16'd0, wb_data}, 32'h5A5A);
        chk("miss_wb_wr_reg", {29'd0, wb_wr_reg}, 32'd3);
        tick();
        chk("b2b_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("b2b_wb_data", {16'd0, wb_data}, 32'h0007);
        chk("b2b_wb_wr_reg", {29'd0, wb_wr_reg}, 32'd4);
        tick();
        chk("b2b_wb_off", {31'd0, wb_valid}, 32'd0);
        chk("miss_err", {31'd0, err}, 32'd0);

        // Store
        drive_ex(1'b1, 16'h0100, 16'h00FF, 1'b0, 1'b1, 1'b1, 3'd6);
        tick();
        drive_ex(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0);
        #1;
        chk("st_mem_wr", {31'd0, mif.mem_wr}, 32'd1);
        chk("st_mem_rd", {31'd0, mif.mem_rd}, 32'd0);
        chk("st_mem_addr", {16'd0, mif.mem_addr}, 32'h0100);
        chk("st_mem_data_in", {16'd0, mif.mem_data_in}, 32'h00FF);
        tick();
        chk("st_mem_wr_off", {31'd0, mif.mem_wr}, 32'd0);
        chk("st_stall_wait", {31'd0, ex_stall}, 32'd1);
        tick();
        mif.mem_done = 1'b1;
        tick();
        mif.mem_done = 1'b0;
        chk("st_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("st_wb_reg_wr", {31'd0, wb_reg_wr}, 32'd0);
        chk("st_err", {31'd0, err}, 32'd0);
        tick();

        // Timeout with TIMEOUT=4
        drive_ex(1'b1, 16'h0200, 16'h0, 1'b1, 1'b0, 1'b1, 3'd1);
        tick();
        drive_ex(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("to_err_w%0d", i), {31'd0, err}, (i == 4) ? 32'd1 : 32'd0);
        end
        tick();
        tick();
        chk("to_err_sticky", {31'd0, err}, 32'd1);
        chk("to_ex_stall", {31'd0, ex_stall}, 32'd1);
        chk("to_state", {30'd0, state_dbg}, 32'd2);

        // Reset while still in WAIT, then a late mem_done
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstw_mem_rd", {31'd0, mif.mem_rd}, 32'd0);
        chk("rstw_mem_wr", {31'd0, mif.mem_wr}, 32'd0);
        chk("rstw_ex_stall", {31'd0, ex_stall}, 32'd0);
        chk("rstw_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rstw_err", {31'd0, err}, 32'd0);
        #1;
        rst_n = 1'b1;
        mif.mem_done = 1'b1;
        tick();
        mif.mem_done = 1'b0;
        chk("late_done_err", {31'd0, err}, 32'd1);
        chk("late_done_wb", {31'd0, wb_valid}, 32'd0);
        tick();
        chk("late_done_wb2", {31'd0, wb_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory stage of the 16-bit pipelined core, directly downstream of the execute-stage ALU. It holds the EX/MEM pipeline register, which captures the ALU result, store data and control. It sequences one load/store at a time against the stalling data memory (request/stall/done interface), stalls upstream stages while an access is outstanding, and drives the registered MEM/WB outputs consumed by writeback.

Parameters:
DATA_W, 16, datapath and address width
REG_W, 3, destination register index width
TIMEOUT, 64, WAIT-state cycle count after which err is raised

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  instruction present at EX output
ex_alu_out  in  DATA_W  ALU result (memory address for ld/st)
ex_wr_data  in  DATA_W  store data
ex_mem_rd  in  1  load
ex_mem_wr  in  1  store
ex_reg_wr  in  1  instruction writes register file
ex_wr_reg  in  REG_W  destination register
ex_halt  in  1  halt instruction
ex_stall  out  1  hold EX and earlier stages this cycle
mem_addr  out  DATA_W  memory address
mem_data_in  out  DATA_W  memory write data
mem_rd  out  1  read request
mem_wr  out  1  write request
mem_stall  in  1  memory cannot accept request this cycle
mem_done  in  1  access complete; read data valid
mem_data_out  in  DATA_W  read data
wb_valid  out  1  MEM/WB holds a completed instruction (one cycle per instruction)
wb_data  out  DATA_W  load data or ALU result
wb_reg_wr  out  1  register write enable
wb_wr_reg  out  REG_W  destination register
wb_halt  out  1  halt reached writeback
err  out  1  sticky protocol/timeout error

Behaviour:
- Reset (async, rst_n low): EX/MEM and MEM/WB registers cleared; state=IDLE; timeout counter=0; err=0. All outputs are 0 while in reset, including mem_rd, mem_wr and ex_stall.
- EX/MEM register (m_*) loads ex_* on a clock edge when ex_stall=0. It holds when ex_stall=1. If ex_valid=0 when loading, m_valid=0 (bubble).
- m_mem = m_valid & (m_mem_rd | m_mem_wr). If both m_mem_rd and m_mem_wr are set: treated as a store, and err is set.
- mem_addr = m_alu_out; mem_data_in = m_wr_data. Both are driven whenever m_valid=1 and are 0 otherwise.
- FSM states IDLE, ISSUE, WAIT. The state is effectively ISSUE whenever a new m_mem instruction sits in EX/MEM.
  - IDLE: no memory op outstanding. mem_rd=mem_wr=0. A non-memory m_valid instruction moves to MEM/WB on the next edge.
  - ISSUE: mem_rd/mem_wr asserted per op.
    - mem_stall=1: request not accepted; stay ISSUE and re-assert next cycle.
    - mem_stall=0 & mem_done=1 (hit): complete this cycle.
    - mem_stall=0 & mem_done=0: go to WAIT.
  - WAIT: mem_rd=mem_wr=0. Counter increments each cycle. mem_done=1 completes the op. When the counter reaches TIMEOUT, err=1; the FSM keeps waiting.
- complete = (ISSUE & ~mem_stall & mem_done) | (WAIT & mem_done).
- ex_stall = m_mem & ~complete. This is combinational, so there is no bubble: the next EX instruction is captured on the completing edge.
- MEM/WB register, on each edge:
  - wb_valid = (m_valid & ~m_mem) | complete.
  - wb_data = mem_data_out for loads, m_alu_out otherwise.
  - wb_reg_wr, wb_wr_reg and wb_halt are copied from m_*; wb_reg_wr is forced 0 for stores.
  - wb_* hold their last value when wb_valid=0; wb_reg_wr and wb_halt are qualified by wb_valid.
- Latency, with the instruction captured at edge N:
  - non-memory or memory hit: wb_valid after edge N+1;
  - miss: wb_valid after the edge that ends the mem_done cycle.
- mem_done in IDLE, or in ISSUE while mem_stall=1: ignored, err set.
- After wb_halt=1 has been presented, later instructions still flow; halting the core is handled elsewhere.
- Reset mid-ISSUE/WAIT abandons the access. A mem_done arriving after rst_n deasserts is in IDLE and therefore sets err.

Test Plan:
- ALU op: ex_alu_out=0x1234, ex_reg_wr=1, ex_wr_reg=5, captured edge N -> wb_valid=1 for one cycle after edge N+1, wb_data=0x1234, wb_wr_reg=5; ex_stall and mem_rd stay 0.
- Load hit: addr 0x0040, mem_done=1 with mem_data_out=0xBEEF in the ISSUE cycle -> mem_rd high exactly 1 cycle with mem_addr=0x0040; ex_stall=0; wb_data=0xBEEF one edge later.
- Load miss with back-to-back ALU op: mem_stall=1 for 2 cycles, then accepted, mem_done 3 cycles later with 0x5A5A -> mem_rd high 3 cycles; ex_stall high until the done cycle; following op 0x0007 captured on the completing edge; wb shows 0x5A5A then 0x0007 on consecutive cycles.
- Store: addr 0x0100, ex_wr_data=0x00FF, accepted and done after 2 cycles -> mem_wr one cycle, mem_data_in=0x00FF; wb_valid=1 with wb_reg_wr=0.
- Reset mid-WAIT: rst_n low while waiting -> mem_rd, mem_wr, ex_stall and wb_valid are 0 immediately with no clock edge; late mem_done after release sets err=1, no wb_valid.
- Timeout: TIMEOUT=4, load accepted and mem_done never asserted -> err=1 after the 4th WAIT cycle, stays 1; ex_stall stays 1.
